int8_dot_acc: RTL and testbench

Sequential signed int8 dot-product stage for the vector MAC datapath. It accepts one (a, b) int8 operand pair per handshake and forms each signed 8×8 product with an 8-cycle radix-2 shift-add multiplier. Each product is added into a two's-complement accumulator. After VEC_LEN pairs it presents the dot product on a valid/ready output port, holds it until consumed, then clears for the next vector.

---
 rtl/int8_dot_acc_if.sv | 21 ++
 rtl/int8_dot_acc.sv | 113 +++++++++++
 tb/tb_int8_dot_acc.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/int8_dot_acc_if.sv
// Operand-in / result-out handshake bundle for the int8 dot-product stage.
// The master side feeds operand pairs and consumes results; the slave side is the datapath.
interface int8_dot_acc_if #(parameter int ACC_W = 20);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc
  );
endinterface

// File: rtl/int8_dot_acc.sv
// Sequential signed int8 dot product: 8-cycle shift-add multiply per pair,
// accumulate VEC_LEN products, then hold the result until consumed.
module int8_dot_acc #(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  int8_dot_acc_if.slave bus,
  output logic          busy
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mcand_q, mcand_d;
  logic [7:0]       mplier_q, mplier_d;
  logic             sign_q, sign_d;
  logic [15:0]      prod_q, prod_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;

  logic             in_fire;
  logic             last_elem;
  logic [15:0]      signed_prod;

  assign in_fire     = bus.in_valid && bus.in_ready;
  assign last_elem   = (elem_cnt_q == CNT_W'(VEC_LEN - 1));
  // Magnitude product never exceeds 16384, so negating in 16 bits is exact.
  assign signed_prod = sign_q ? (~prod_q + 16'd1) : prod_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_fire)                 state_d = MUL;
      MUL:  if (bit_cnt_q == 3'd7)       state_d = ACC;
      ACC:  state_d = last_elem ? DONE : IDLE;
      DONE: if (bus.out_ready)           state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_acc   = acc_q;
    busy          = (state_q != IDLE) || (elem_cnt_q != '0);
  end

  // Datapath next values
  always_comb begin
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    sign_d     = sign_q;
    prod_d     = prod_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    elem_cnt_d = elem_cnt_q;
    case (state_q)
      IDLE: if (in_fire) begin
        // |-128| = 128 still fits the 8-bit unsigned magnitude.
        mcand_d   = bus.in_a[7] ? (~bus.in_a + 8'd1) : bus.in_a;
        mplier_d  = bus.in_b[7] ? (~bus.in_b + 8'd1) : bus.in_b;
        sign_d    = bus.in_a[7] ^ bus.in_b[7];
        prod_d    = '0;
        bit_cnt_d = '0;
      end
      MUL: begin
        if (mplier_q[bit_cnt_q]) prod_d = prod_q + ({8'd0, mcand_q} << bit_cnt_q);
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      ACC: begin
        acc_d      = acc_q + {{(ACC_W-16){signed_prod[15]}}, signed_prod};
        elem_cnt_d = elem_cnt_q + CNT_W'(1);
      end
      DONE: if (bus.out_ready) begin
        acc_d      = '0;
        elem_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      sign_q     <= 1'b0;
      prod_q     <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      elem_cnt_q <= '0;
    end else begin
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      sign_q     <= sign_d;
      prod_q     <= prod_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end
endmodule

// File: tb/tb_int8_dot_acc.sv
// Directed bench for int8_dot_acc: expected dot products are queued when a
// vector is driven and compared when the result handshake occurs.
module tb_int8_dot_acc;
  localparam int VEC_LEN = 8;
  localparam int ACC_W   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int checks = 0, errors = 0, cyc = 0, spurious = 0, last_hs = 0;
  bit expect_out = 1'b0;
  int exp_q[$];
  int a_v[VEC_LEN], b_v[VEC_LEN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int8_dot_acc_if #(.ACC_W(ACC_W)) bus ();

  int8_dot_acc #(.VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  // A result appearing outside an expected window is a premature/stray output.
  always @(negedge clk) if (rst_n && bus.out_valid && !expect_out) spurious++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n pairs with in_valid held high; called and returns at a negedge.
  task automatic send_vec(input int n, input bit push);
    int sum = 0, prev = -1, w;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'(a_v[i]);
      bus.in_b = 8'(b_v[i]);
      w = 0;
      while (!bus.in_ready && w < 40) begin @(negedge clk); w++; end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      last_hs = cyc;
      if (prev >= 0) chk("hs_spacing", last_hs - prev, 32'd10);
      prev = last_hs;
      sum += a_v[i] * b_v[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_a = 8'hxx;
    bus.in_b = 8'hxx;
    if (push) exp_q.push_back(sum);
  endtask

  // Waits for the result, optionally stalls `hold` cycles, then consumes it.
  task automatic recv(input int hold);
    int w = 0, e = 0;
    logic [ACC_W-1:0] ev;
    expect_out = 1'b1;
    while (!bus.out_valid && w < 40) begin @(negedge clk); w++; end
    chk("out_valid_rise", 32'(bus.out_valid), 32'd1);
    chk("out_latency", cyc - last_hs, 32'd10);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    ev = ACC_W'(e);
    chk("out_acc", 32'(bus.out_acc), 32'(ev));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_acc", 32'(bus.out_acc), 32'(ev));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("consumed_valid", 32'(bus.out_valid), 32'd0);
    chk("consumed_in_ready", 32'(bus.in_ready), 32'd1);
    chk("consumed_busy", 32'(busy), 32'd0);
    chk("consumed_acc", 32'(bus.out_acc), 32'd0);
    bus.out_ready = 1'b0;
    expect_out = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd7;
    bus.in_b      = 8'd9;
    bus.out_ready = 1'b0;

    // Reset held 3 cycles with in_valid asserted
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_acc", 32'(bus.out_acc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy_after", 32'(busy), 32'd0);

    // Basic vector
    a_v = '{default: 3};
    b_v = '{default: 4};
    send_vec(VEC_LEN, 1'b1);
    recv(0);

    // Extremes
    a_v = '{default: -128};
    b_v = '{default: -128};
    send_vec(VEC_LEN, 1'b1);
    recv(0);
    b_v = '{default: 127};
    send_vec(VEC_LEN, 1'b1);
    recv(0);

    // Mixed signs
    a_v = '{1, -2, 3, -4, 5, -6, 7, -8};
    b_v = '{default: -1};
    send_vec(VEC_LEN, 1'b1);
    recv(0);

    // Backpressure, then a vector proving the accumulator cleared
    a_v = '{-5, 17, -100, 33, 127, -128, 0, 64};
    b_v = '{9, -3, -77, 0, 127, 1, -128, -64};
    send_vec(VEC_LEN, 1'b1);
    recv(5);
    a_v = '{default: 1};
    b_v = '{default: 1};
    send_vec(VEC_LEN, 1'b1);
    recv(0);

    // Reset mid-vector discards the partial sum
    a_v = '{default: 10};
    b_v = '{default: 10};
    send_vec(3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    a_v = '{default: 2};
    b_v = '{default: 5};
    send_vec(VEC_LEN, 1'b1);
    recv(0);

    repeat (3) @(negedge clk);
    chk("no_stray_out_valid", spurious, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
